bp_me_mem_arbiter: RTL and testbench

Shares one memory port among `num_cce_p` CCEs. Each CCE has four mem channels:
- `mem_cmd`: read, answered by `mem_data_resp`.
- `mem_data_cmd`: writeback, answered by `mem_resp`.

The block sits between the CCE array and a single `bp_mem` instance. It grants one CCE transaction at a time in round-robin order, then routes the memory's response back to the granted CCE. Exactly one transaction is outstanding at the memory.

---
 rtl/bp_me_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_bp_me_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_mem_arbiter.sv
// Shares one memory port among num_cce_p CCEs. Grants one transaction at a time
// in round-robin order and routes the memory response back to the granted CCE.
`timescale 1ns/1ps
module bp_me_mem_arbiter #(
   parameter int  num_cce_p             = 2,
   parameter int  mem_cmd_width_p       = 64,
   parameter int  mem_data_cmd_width_p  = 576,
   parameter int  mem_resp_width_p      = 64,
   parameter int  mem_data_resp_width_p = 576,
   localparam int lg_num_cce_lp         = (num_cce_p > 1) ? $clog2(num_cce_p) : 1
) (
   input  logic                                               clk_i,
   input  logic                                               reset_i,

   input  logic [num_cce_p-1:0][mem_cmd_width_p-1:0]          cce_mem_cmd_i,
   input  logic [num_cce_p-1:0]                               cce_mem_cmd_v_i,
   output logic [num_cce_p-1:0]                               cce_mem_cmd_yumi_o,

   input  logic [num_cce_p-1:0][mem_data_cmd_width_p-1:0]     cce_mem_data_cmd_i,
   input  logic [num_cce_p-1:0]                               cce_mem_data_cmd_v_i,
   output logic [num_cce_p-1:0]                               cce_mem_data_cmd_yumi_o,

   output logic [num_cce_p-1:0][mem_resp_width_p-1:0]         cce_mem_resp_o,
   output logic [num_cce_p-1:0]                               cce_mem_resp_v_o,
   input  logic [num_cce_p-1:0]                               cce_mem_resp_ready_i,

   output logic [num_cce_p-1:0][mem_data_resp_width_p-1:0]    cce_mem_data_resp_o,
   output logic [num_cce_p-1:0]                               cce_mem_data_resp_v_o,
   input  logic [num_cce_p-1:0]                               cce_mem_data_resp_ready_i,

   output logic [mem_cmd_width_p-1:0]                         mem_cmd_o,
   output logic                                               mem_cmd_v_o,
   input  logic                                               mem_cmd_yumi_i,

   output logic [mem_data_cmd_width_p-1:0]                    mem_data_cmd_o,
   output logic                                               mem_data_cmd_v_o,
   input  logic                                               mem_data_cmd_yumi_i,

   input  logic [mem_resp_width_p-1:0]                        mem_resp_i,
   input  logic                                               mem_resp_v_i,
   output logic                                               mem_resp_ready_o,

   input  logic [mem_data_resp_width_p-1:0]                   mem_data_resp_i,
   input  logic                                               mem_data_resp_v_i,
   output logic                                               mem_data_resp_ready_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

   state_e                   state_r;
   logic [lg_num_cce_lp-1:0] grant_r;
   logic [lg_num_cce_lp-1:0] rr_r;
   logic                     kind_r;

   logic                     in_issue;
   logic                     in_wait;
   logic [num_cce_p-1:0]     req;
   logic                     req_found;
   logic [lg_num_cce_lp-1:0] req_idx;
   int                       cand;
   logic [lg_num_cce_lp-1:0] cand_idx;
   logic                     issue_yumi;
   logic                     resp_hs;
   logic                     grant_last;
   logic [lg_num_cce_lp-1:0] rr_next;

   assign in_issue = (state_r == ISSUE);
   assign in_wait  = (state_r == WAIT);

   // Rotating search from rr_r; wrap uses an explicit compare so that
   // non-power-of-2 CCE counts never land on an invalid index.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < num_cce_p; k++) begin
         cand = int'(rr_r) + k;
         if (cand >= num_cce_p) begin
            cand = cand - num_cce_p;
         end
         cand_idx = lg_num_cce_lp'(cand);
         if (!req_found && req[cand_idx]) begin
            req_found = 1'b1;
            req_idx   = cand_idx;
         end
      end
   end

   assign grant_last = (int'(grant_r) == num_cce_p - 1);
   assign rr_next    = grant_last ? '0 : grant_r + lg_num_cce_lp'(1);

   assign issue_yumi = kind_r ? mem_data_cmd_yumi_i : mem_cmd_yumi_i;

   // Only the response kind matching the outstanding command can complete;
   // the other kind sees ready low and waits at the memory.
   assign mem_resp_ready_o      = in_wait &  kind_r & cce_mem_resp_ready_i[grant_r];
   assign mem_data_resp_ready_o = in_wait & ~kind_r & cce_mem_data_resp_ready_i[grant_r];
   assign resp_hs = (mem_resp_v_i & mem_resp_ready_o)
                  | (mem_data_resp_v_i & mem_data_resp_ready_o);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         grant_r <= '0;
         rr_r    <= '0;
         kind_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_found) begin
                  grant_r <= req_idx;
                  kind_r  <= cce_mem_data_cmd_v_i[req_idx];
                  state_r <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_yumi) begin
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               if (resp_hs) begin
                  rr_r    <= rr_next;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign mem_cmd_o        = cce_mem_cmd_i[grant_r];
   assign mem_data_cmd_o   = cce_mem_data_cmd_i[grant_r];
   assign mem_cmd_v_o      = in_issue & ~kind_r;
   assign mem_data_cmd_v_o = in_issue &  kind_r;

   for (genvar gi = 0; gi < num_cce_p; gi++) begin : g_cce
      logic sel;
      assign sel     = (int'(grant_r) == gi);
      assign req[gi] = cce_mem_cmd_v_i[gi] | cce_mem_data_cmd_v_i[gi];

      assign cce_mem_cmd_yumi_o[gi]      = in_issue & ~kind_r & sel & mem_cmd_yumi_i;
      assign cce_mem_data_cmd_yumi_o[gi] = in_issue &  kind_r & sel & mem_data_cmd_yumi_i;

      assign cce_mem_resp_o[gi]        = mem_resp_i;
      assign cce_mem_data_resp_o[gi]   = mem_data_resp_i;
      assign cce_mem_resp_v_o[gi]      = in_wait &  kind_r & sel & mem_resp_v_i;
      assign cce_mem_data_resp_v_o[gi] = in_wait & ~kind_r & sel & mem_data_resp_v_i;
   end

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
// Bench for bp_me_mem_arbiter with three CCEs: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
`timescale 1ns/1ps
module tb_bp_me_mem_arbiter;
   localparam int N   = 3;
   localparam int CW  = 32;
   localparam int DCW = 64;
   localparam int RW  = 32;
   localparam int DRW = 64;

   logic clk = 1'b0;
   logic reset_i;

   logic [N-1:0][CW-1:0]  cce_mem_cmd_i;
   logic [N-1:0]          cce_mem_cmd_v_i, cce_mem_cmd_yumi_o;
   logic [N-1:0][DCW-1:0] cce_mem_data_cmd_i;
   logic [N-1:0]          cce_mem_data_cmd_v_i, cce_mem_data_cmd_yumi_o;
   logic [N-1:0][RW-1:0]  cce_mem_resp_o;
   logic [N-1:0]          cce_mem_resp_v_o, cce_mem_resp_ready_i;
   logic [N-1:0][DRW-1:0] cce_mem_data_resp_o;
   logic [N-1:0]          cce_mem_data_resp_v_o, cce_mem_data_resp_ready_i;
   logic [CW-1:0]         mem_cmd_o;
   logic                  mem_cmd_v_o, mem_cmd_yumi_i;
   logic [DCW-1:0]        mem_data_cmd_o;
   logic                  mem_data_cmd_v_o, mem_data_cmd_yumi_i;
   logic [RW-1:0]         mem_resp_i;
   logic                  mem_resp_v_i, mem_resp_ready_o;
   logic [DRW-1:0]        mem_data_resp_i;
   logic                  mem_data_resp_v_i, mem_data_resp_ready_o;

   bp_me_mem_arbiter #(
      .num_cce_p(N), .mem_cmd_width_p(CW), .mem_data_cmd_width_p(DCW),
      .mem_resp_width_p(RW), .mem_data_resp_width_p(DRW)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .cce_mem_cmd_i(cce_mem_cmd_i), .cce_mem_cmd_v_i(cce_mem_cmd_v_i),
      .cce_mem_cmd_yumi_o(cce_mem_cmd_yumi_o),
      .cce_mem_data_cmd_i(cce_mem_data_cmd_i), .cce_mem_data_cmd_v_i(cce_mem_data_cmd_v_i),
      .cce_mem_data_cmd_yumi_o(cce_mem_data_cmd_yumi_o),
      .cce_mem_resp_o(cce_mem_resp_o), .cce_mem_resp_v_o(cce_mem_resp_v_o),
      .cce_mem_resp_ready_i(cce_mem_resp_ready_i),
      .cce_mem_data_resp_o(cce_mem_data_resp_o), .cce_mem_data_resp_v_o(cce_mem_data_resp_v_o),
      .cce_mem_data_resp_ready_i(cce_mem_data_resp_ready_i),
      .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
      .mem_data_cmd_o(mem_data_cmd_o), .mem_data_cmd_v_o(mem_data_cmd_v_o),
      .mem_data_cmd_yumi_i(mem_data_cmd_yumi_i),
      .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
      .mem_data_resp_i(mem_data_resp_i), .mem_data_resp_v_i(mem_data_resp_v_i),
      .mem_data_resp_ready_o(mem_data_resp_ready_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Transaction-level model: is a CCE granted, has its command been accepted,
   // which CCE, which kind, and who has first priority next time.
   bit m_have, m_issued, m_wb;
   int m_who, m_prio;
   int glog[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_issued = 0; m_wb = 0; m_who = 0; m_prio = 0;
   endtask

   task automatic clear_inputs();
      cce_mem_cmd_i = '0; cce_mem_cmd_v_i = '0;
      cce_mem_data_cmd_i = '0; cce_mem_data_cmd_v_i = '0;
      cce_mem_resp_ready_i = '0; cce_mem_data_resp_ready_i = '0;
      mem_cmd_yumi_i = 1'b0; mem_data_cmd_yumi_i = 1'b0;
      mem_resp_i = '0; mem_resp_v_i = 1'b0;
      mem_data_resp_i = '0; mem_data_resp_v_i = 1'b0;
   endtask

   // Called 1ns after a rising edge; compares mid-cycle.
   task automatic settle();
      logic [N-1:0] e_cy, e_dcy, e_rv, e_drv;
      logic e_cv, e_dcv, e_rr, e_drr;
      #4;
      e_cy = '0; e_dcy = '0; e_rv = '0; e_drv = '0;
      e_cv = 1'b0; e_dcv = 1'b0; e_rr = 1'b0; e_drr = 1'b0;
      if (m_have && !m_issued) begin
         e_cv  = !m_wb;
         e_dcv = m_wb;
         if (!m_wb && mem_cmd_yumi_i)     e_cy[m_who]  = 1'b1;
         if (m_wb && mem_data_cmd_yumi_i) e_dcy[m_who] = 1'b1;
      end else if (m_have) begin
         if (m_wb) begin
            e_rr = cce_mem_resp_ready_i[m_who];
            e_rv[m_who] = mem_resp_v_i;
         end else begin
            e_drr = cce_mem_data_resp_ready_i[m_who];
            e_drv[m_who] = mem_data_resp_v_i;
         end
      end
      chk("mem_cmd_v", 64'(mem_cmd_v_o), 64'(e_cv));
      chk("mem_data_cmd_v", 64'(mem_data_cmd_v_o), 64'(e_dcv));
      chk("cmd_yumi", 64'(cce_mem_cmd_yumi_o), 64'(e_cy));
      chk("data_cmd_yumi", 64'(cce_mem_data_cmd_yumi_o), 64'(e_dcy));
      chk("mem_resp_ready", 64'(mem_resp_ready_o), 64'(e_rr));
      chk("mem_data_resp_ready", 64'(mem_data_resp_ready_o), 64'(e_drr));
      chk("resp_v", 64'(cce_mem_resp_v_o), 64'(e_rv));
      chk("data_resp_v", 64'(cce_mem_data_resp_v_o), 64'(e_drv));
      if (e_cv)  chk("mem_cmd", 64'(mem_cmd_o), 64'(cce_mem_cmd_i[m_who]));
      if (e_dcv) chk("mem_data_cmd", 64'(mem_data_cmd_o), 64'(cce_mem_data_cmd_i[m_who]));
      if (e_rv[m_who])  chk("resp_payload", 64'(cce_mem_resp_o[m_who]), 64'(mem_resp_i));
      if (e_drv[m_who]) chk("data_resp_payload", 64'(cce_mem_data_resp_o[m_who]), 64'(mem_data_resp_i));
      for (int i = 0; i < N; i++) begin
         if (cce_mem_cmd_yumi_o[i] || cce_mem_data_cmd_yumi_o[i]) glog.push_back(i);
      end
   endtask

   // Applies the rules for the coming edge, then steps to 1ns after it.
   task automatic advance();
      int  c;
      bit  found;
      logic hs;
      if (!m_have) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            c = (m_prio + k) % N;
            if (!found && (cce_mem_cmd_v_i[c] || cce_mem_data_cmd_v_i[c])) begin
               found = 1; m_have = 1; m_issued = 0; m_who = c;
               m_wb = cce_mem_data_cmd_v_i[c];
            end
         end
      end else if (!m_issued) begin
         if (m_wb ? mem_data_cmd_yumi_i : mem_cmd_yumi_i) m_issued = 1;
      end else begin
         hs = m_wb ? (mem_resp_v_i & cce_mem_resp_ready_i[m_who])
                   : (mem_data_resp_v_i & cce_mem_data_resp_ready_i[m_who]);
         if (hs) begin
            $display("txn: cce=%0d kind=%s", m_who, m_wb ? "writeback" : "read");
            m_prio = (m_who + 1) % N;
            m_have = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) begin
         if (!(m_have && !m_issued && m_who == i)) begin
            cce_mem_cmd_v_i[i]      = ($urandom_range(0, 2) == 0);
            cce_mem_data_cmd_v_i[i] = ($urandom_range(0, 3) == 0);
            cce_mem_cmd_i[i]        = $urandom;
            cce_mem_data_cmd_i[i]   = {$urandom, $urandom};
         end
         cce_mem_resp_ready_i[i]      = ($urandom_range(0, 3) != 0);
         cce_mem_data_resp_ready_i[i] = ($urandom_range(0, 3) != 0);
      end
      mem_cmd_yumi_i      = $urandom_range(0, 1) == 1;
      mem_data_cmd_yumi_i = $urandom_range(0, 1) == 1;
      mem_resp_v_i        = ($urandom_range(0, 2) == 0);
      mem_data_resp_v_i   = ($urandom_range(0, 2) == 0);
      mem_resp_i          = $urandom;
      mem_data_resp_i     = {$urandom, $urandom};
   endtask

   int exp_order[6] = '{0, 1, 2, 0, 1, 2};

   initial begin
      clear_inputs();
      model_reset();
      reset_i = 1'b1;
      #2;
      chk("rst_mem_cmd_v", 64'(mem_cmd_v_o), 64'(0));
      chk("rst_resp_ready", 64'({mem_resp_ready_o, mem_data_resp_ready_o}), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      cycle();

      // Single read from CCE0
      cce_mem_cmd_v_i[0] = 1'b1; cce_mem_cmd_i[0] = 32'h1111_0000;
      settle();
      chk("idle_no_cmd_v", 64'(mem_cmd_v_o), 64'(0));
      advance();
      mem_cmd_yumi_i = 1'b1;
      settle();
      chk("read_cmd_v", 64'(mem_cmd_v_o), 64'(1));
      chk("read_yumi", 64'(cce_mem_cmd_yumi_o), 64'(3'b001));
      advance();
      cce_mem_cmd_v_i = '0; mem_cmd_yumi_i = 1'b0;
      mem_data_resp_v_i = 1'b1; mem_data_resp_i = 64'hABCD;
      cce_mem_data_resp_ready_i = '1;
      settle();
      chk("read_resp_v", 64'(cce_mem_data_resp_v_o), 64'(3'b001));
      chk("read_resp_data", 64'(cce_mem_data_resp_o[0]), 64'hABCD);
      advance();
      clear_inputs();
      // CCE1 granted, then reset asynchronously mid-ISSUE
      cce_mem_cmd_v_i[1] = 1'b1;
      cycle();
      mem_cmd_yumi_i = 1'b1;
      #3;
      chk("pre_rst_yumi", 64'(cce_mem_cmd_yumi_o), 64'(3'b010));
      reset_i = 1'b1;
      #1;
      chk("async_rst_cmd_v", 64'(mem_cmd_v_o), 64'(0));
      chk("async_rst_yumi", 64'({cce_mem_cmd_yumi_o, cce_mem_data_cmd_yumi_o}), 64'(0));
      model_reset();
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      clear_inputs();
      // Priority pointer back at 0: CCE0 beats CCE1
      cce_mem_cmd_v_i = 3'b011;
      cycle();
      mem_cmd_yumi_i = 1'b1;
      settle();
      chk("post_rst_rr", 64'(cce_mem_cmd_yumi_o), 64'(3'b001));
      advance();
      clear_inputs();
      mem_data_resp_v_i = 1'b1; cce_mem_data_resp_ready_i = '1;
      cycle();
      clear_inputs();
      cycle();

      // Writeback priority for CCE1 holding both kinds
      cce_mem_cmd_v_i[1] = 1'b1; cce_mem_data_cmd_v_i[1] = 1'b1;
      cce_mem_data_cmd_i[1] = 64'h0BAD_F00D_0000_0001;
      cycle();
      mem_data_cmd_yumi_i = 1'b1;
      settle();
      chk("wb_first", 64'({mem_data_cmd_v_o, mem_cmd_v_o}), 64'(2'b10));
      chk("wb_yumi", 64'(cce_mem_data_cmd_yumi_o), 64'(3'b010));
      advance();
      cce_mem_data_cmd_v_i[1] = 1'b0; mem_data_cmd_yumi_i = 1'b0;
      mem_resp_v_i = 1'b1; mem_resp_i = 32'h5A5A; cce_mem_resp_ready_i = '1;
      settle();
      chk("wb_resp_v", 64'(cce_mem_resp_v_o), 64'(3'b010));
      advance();
      mem_resp_v_i = 1'b0;
      cycle();
      mem_cmd_yumi_i = 1'b1;
      settle();
      chk("read_after_wb", 64'(cce_mem_cmd_yumi_o), 64'(3'b010));
      advance();
      clear_inputs();
      // Wrong-kind hold-off, then backpressure
      mem_resp_v_i = 1'b1; cce_mem_resp_ready_i = '1; cce_mem_data_resp_ready_i = '1;
      settle();
      chk("holdoff_ready", 64'(mem_resp_ready_o), 64'(0));
      chk("holdoff_resp_v", 64'(cce_mem_resp_v_o), 64'(0));
      advance();
      mem_data_resp_v_i = 1'b1; mem_data_resp_i = 64'h1234; cce_mem_data_resp_ready_i = 3'b101;
      repeat (5) begin
         settle();
         chk("bp_ready", 64'(mem_data_resp_ready_o), 64'(0));
         advance();
      end
      mem_resp_v_i = 1'b0; cce_mem_data_resp_ready_i = '1;
      settle();
      chk("bp_release", 64'(cce_mem_data_resp_v_o), 64'(3'b010));
      advance();
      clear_inputs();

      // Fairness from a fresh reset with everyone requesting
      reset_i = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      cce_mem_cmd_v_i = '1; mem_cmd_yumi_i = 1'b1;
      mem_data_resp_v_i = 1'b1; cce_mem_data_resp_ready_i = '1;
      glog.delete();
      repeat (18) cycle();
      chk("fair_count", 64'(glog.size()), 64'(6));
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", 64'(glog[i]), 64'(exp_order[i]));
      clear_inputs();
      repeat (3) cycle();

      repeat (3000) begin
         drive_random();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule
